demux_if_bal_9_1_reg: RTL and testbench

DEMUX_IF_BAL_9_1_REG -- requirements
Module: demux_if_bal_9_1_reg

---
 rtl/demux_if_bal_9_1_reg.sv | 137 +++++++++++++
 tb/tb_demux_if_bal_9_1_reg.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/demux_if_bal_9_1_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : demux_if_bal_9_1_reg                                          |
// | Description : Single-entry registered demux routing one beat to one of N   |
// |               lanes; optional drop counter via DEMUX_DROP_CNT_EN.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module demux_if_bal_9_1_reg #(
    parameter int N  = 9,
    parameter int W  = 1,
    parameter int SW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_data,
    input  logic [SW-1:0]  in_sel,
    output logic [N-1:0]   out_valid,
    input  logic [N-1:0]   out_ready,
    output logic [N*W-1:0] out_data,
`ifdef DEMUX_DROP_CNT_EN
    output logic [15:0]    drop_cnt,
`endif
    output logic           err
);

    localparam logic [0:0]  c_ST_EMPTY = 1'b0;
    localparam logic [0:0]  c_ST_FULL  = 1'b1;
    localparam logic [SW:0] c_NUM_LANE = (SW+1)'(N);

    logic [0:0]   r_state;
    logic [0:0]   w_state_nxt;
    logic [W-1:0] r_data_q;
    logic [SW-1:0] r_sel_q;
    logic         r_err;

    logic         w_full;
    logic [N-1:0] w_lane_hit;
    logic         w_sel_ready;
    logic         w_accept;
    logic         w_in_range;
    logic         w_consume;
    logic         w_load;
    logic         w_drop;

    assign w_full = (r_state == c_ST_FULL);

    // One-hot decode of the held select; drives both out_valid and the ready mux.
    generate
        for (genvar k = 0; k < N; k++) begin : g_lane
            assign w_lane_hit[k]          = (r_sel_q == SW'(k));
            assign out_valid[k]           = w_full & w_lane_hit[k];
            assign out_data[k*W +: W]     = out_valid[k] ? r_data_q : '0;
        end
    endgenerate

    assign w_sel_ready = |(w_lane_hit & out_ready);
    assign w_consume   = w_full & w_sel_ready;
    assign in_ready    = ~w_full | w_sel_ready;
    assign w_accept    = in_valid & in_ready;
    assign w_in_range  = ({1'b0, in_sel} < c_NUM_LANE);
    assign err         = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            c_ST_EMPTY: begin
                if (w_accept) begin
                    if (w_in_range) begin
                        w_load      = 1'b1;
                        w_state_nxt = c_ST_FULL;
                    end else begin
                        w_drop      = 1'b1;
                    end
                end
            end
            c_ST_FULL: begin
                // An out-of-range beat arriving on a consume edge still empties the buffer.
                if (w_accept && w_in_range) begin
                    w_load      = 1'b1;
                    w_state_nxt = c_ST_FULL;
                end else begin
                    w_drop      = w_accept;
                    if (w_consume) begin
                        w_state_nxt = c_ST_EMPTY;
                    end
                end
            end
            default: begin
                w_state_nxt = c_ST_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_q <= '0;
            r_sel_q  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_err <= w_drop;
            if (w_load) begin
                r_data_q <= in_data;
                r_sel_q  <= in_sel;
            end
        end
    end

`ifdef DEMUX_DROP_CNT_EN
    logic [15:0] r_drop_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign drop_cnt = r_drop_cnt;
`else
    // Drop counter not built; discarded beats are reported only through err.
`endif

endmodule
`default_nettype wire

// File: tb/tb_demux_if_bal_9_1_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_demux_if_bal_9_1_reg                                       |
// | Description : Randomised self-checking bench against a queue-based model.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_demux_if_bal_9_1_reg;

    localparam int N  = 9;
    localparam int W  = 1;
    localparam int SW = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_data;
    logic [SW-1:0]  in_sel;
    logic [N-1:0]   out_valid;
    logic [N-1:0]   out_ready;
    logic [N*W-1:0] out_data;
    logic           err;
`ifdef DEMUX_DROP_CNT_EN
    logic [15:0]    drop_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference: the buffer is a queue of at most one {sel,data} beat.
    int held_sel[$];
    int held_dat[$];
    bit m_err;
    int m_cnt;

    demux_if_bal_9_1_reg #(.N(N), .W(W), .SW(SW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef DEMUX_DROP_CNT_EN
        .drop_cnt  (drop_cnt),
`endif
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        held_sel.delete();
        held_dat.delete();
        m_err = 1'b0;
        m_cnt = 0;
    endtask

    // One clock: apply inputs, check outputs mid-cycle, then advance the model on the edge.
    task automatic cycle(input logic v, input logic [SW-1:0] s, input logic [W-1:0] d,
                         input logic [N-1:0] ordy, input logic r);
        logic          e_ready;
        logic [N-1:0]  e_valid;
        logic [N*W-1:0] e_data;
        bit            accept;
        bit            consume;
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = ordy;
        rst       = r;
        e_valid = '0;
        e_data  = '0;
        if (held_sel.size() > 0) begin
            e_valid = N'(1) << held_sel[0];
            e_data  = N'(held_dat[0]) << (held_sel[0] * W);
            e_ready = ordy[held_sel[0]];
        end else begin
            e_ready = 1'b1;
        end
        @(negedge clk);
        check_val("in_ready", 32'(in_ready), 32'(e_ready));
        check_val("out_valid", 32'(out_valid), 32'(e_valid));
        check_val("out_data", 32'(out_data), 32'(e_data));
        check_val("err", 32'(err), 32'(m_err));
`ifdef DEMUX_DROP_CNT_EN
        check_val("drop_cnt", 32'(drop_cnt), m_cnt);
`endif
        @(posedge clk);
        accept  = v && e_ready;
        consume = (held_sel.size() > 0) && e_ready;
        if (r) begin
            model_clear();
        end else begin
            m_err = accept && (int'(s) >= N);
            if (m_err && m_cnt < 65535) m_cnt++;
            if (consume) begin
                void'(held_sel.pop_front());
                void'(held_dat.pop_front());
            end
            if (accept && int'(s) < N) begin
                held_sel.push_back(int'(s));
                held_dat.push_back(int'(d));
            end
        end
        #1;
    endtask

    initial begin
        in_valid  = 1'b0;
        in_sel    = '0;
        in_data   = '0;
        out_ready = '0;
        rst       = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_clear();

        // Single beat to lane 4, then stream every lane back to back.
        cycle(1'b1, 4'd4, 1'b1, '1, 1'b0);
        cycle(1'b0, 4'd0, 1'b0, '1, 1'b0);
        for (int i = 0; i < N; i++) cycle(1'b1, SW'(i), 1'(i), '1, 1'b0);
        cycle(1'b0, 4'd0, 1'b0, '1, 1'b0);

        // Hold lane 8 against backpressure, with a competing beat offered.
        cycle(1'b1, 4'd8, 1'b1, '1, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1, 4'd2, 1'b0, 9'h0FF, 1'b0);
        cycle(1'b0, 4'd0, 1'b0, 9'h100, 1'b0);
        cycle(1'b0, 4'd0, 1'b0, '0, 1'b0);

        // Out-of-range selects are dropped with an err pulse.
        cycle(1'b1, 4'd9, 1'b1, '1, 1'b0);
        cycle(1'b1, 4'd15, 1'b1, '1, 1'b0);
        cycle(1'b0, 4'd0, 1'b0, '1, 1'b0);
        cycle(1'b0, 4'd0, 1'b0, '1, 1'b0);

        // Drop on the consume edge empties the buffer.
        cycle(1'b1, 4'd5, 1'b1, '0, 1'b0);
        cycle(1'b1, 4'd12, 1'b0, 9'h020, 1'b0);
        cycle(1'b0, 4'd0, 1'b0, '1, 1'b0);

        // Reset while lane 3 is held.
        cycle(1'b1, 4'd3, 1'b1, '0, 1'b0);
        cycle(1'b0, 4'd0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 4'd0, 1'b0, '1, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), SW'($urandom_range(0, 15)), W'($urandom),
                  N'($urandom), 1'($urandom_range(0, 99) == 0));
        end

`ifdef DEMUX_DROP_CNT_EN
        cycle(1'b0, 4'd0, 1'b0, '1, 1'b1);
        for (int i = 0; i < 65537; i++) cycle(1'b1, 4'd12, 1'b0, '1, 1'b0);
        cycle(1'b0, 4'd0, 1'b0, '1, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
